// File: rtl/master_bus_pkg.sv
// Shared types for the serial system bus initiator: response/status codes, FSM encoding, frame geometry.
package master_bus_pkg;

    localparam int SLAVE_W    = 2;
    localparam int MEM_ADDR_W = 12;
    localparam int FRAME_W    = SLAVE_W + 1 + MEM_ADDR_W;
    localparam int DATA_W     = 8;
    localparam int BITCNT_W   = 4;

    typedef enum logic [1:0] {
        RESP_NAK  = 2'b00,
        RESP_BUSY = 2'b01,
        RESP_OK   = 2'b10,
        RESP_DONE = 2'b11
    } resp_e;

    typedef enum logic [1:0] {
        STAT_OK       = 2'b00,
        STAT_NAK      = 2'b01,
        STAT_DONE_TO  = 2'b10,
        STAT_SPLIT_TO = 2'b11
    } status_e;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_REQ,
        ST_START,
        ST_ADDR,
        ST_WAIT_RESP,
        ST_SPLIT_WAIT,
        ST_WDATA,
        ST_RDATA,
        ST_WAIT_DONE,
        ST_FINISH
    } state_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/bus_shift_reg.sv
// Loadable shift register, MSB first, with a saturating count of bits shifted since the last load.
module bus_shift_reg
    import master_bus_pkg::*;
#(
    parameter int WIDTH = FRAME_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load,
    input  logic [WIDTH-1:0]    load_data,
    input  logic                shift,
    input  logic                serial_in,
    output logic [WIDTH-1:0]    data,
    output logic [BITCNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset) begin
            data  <= '0;
            count <= '0;
        end else if (load) begin
            data  <= load_data;
            count <= '0;
        end else if (shift) begin
            data <= {data[WIDTH-2:0], serial_in};
            if (count != '1) begin
                count <= count + BITCNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/master_interface.sv
// Initiator end of the serial system bus: arbitration, address frame, split handling, data shift, completion.
//   state      | meaning
//   IDLE       | ready for a core request
//   REQ        | bus_request high, waiting for grant
//   START      | start bit on addr (one cycle)
//   ADDR       | 15 frame bits on addr, MSB first
//   WAIT_RESP  | waiting for OK/BUSY, response timer running
//   SPLIT_WAIT | slave split; bus released until arbiter re-grants
//   WDATA      | 8 write bits on w_data
//   RDATA      | 8 read bits sampled from r_data
//   WAIT_DONE  | waiting for DONE, done timer running
//   FINISH     | one-cycle completion to the core
module master_interface
    import master_bus_pkg::*;
#(
    parameter int RESP_TIMEOUT  = 8,
    parameter int DONE_TIMEOUT  = 4,
    parameter int SPLIT_TIMEOUT = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [SLAVE_W-1:0]    req_slave,
    input  logic [MEM_ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic [1:0]            rsp_status,
    output logic                  bus_request,
    input  logic                  bus_grant,
    output logic                  master_en,
    output logic                  addr,
    output logic                  w_data,
    input  logic                  r_data,
    input  logic [1:0]            response
);

    localparam int TMR_W = $clog2(max3(RESP_TIMEOUT, DONE_TIMEOUT, SPLIT_TIMEOUT)) + 1;

    state_e               state, state_d;
    logic [TMR_W-1:0]     tmr, tmr_d;
    logic                 tmr_tc;
    logic                 accept;
    logic                 write_q;
    logic [DATA_W-1:0]    wdata_q;

    logic                 addr_d, w_data_d, master_en_d, bus_request_d, rsp_valid_d;
    logic [1:0]           rsp_status_d;
    logic [DATA_W-1:0]    rsp_rdata_d;

    logic                 tx_load, tx_shift, rx_load, rx_shift;
    logic [FRAME_W-1:0]   tx_load_data, tx_data, rx_data;
    logic [BITCNT_W-1:0]  tx_count, rx_count;
    logic                 unused_bits;

    bus_shift_reg #(.WIDTH(FRAME_W)) u_tx (
        .clk       (clk),
        .reset     (reset),
        .load      (tx_load),
        .load_data (tx_load_data),
        .shift     (tx_shift),
        .serial_in (1'b0),
        .data      (tx_data),
        .count     (tx_count)
    );

    bus_shift_reg #(.WIDTH(FRAME_W)) u_rx (
        .clk       (clk),
        .reset     (reset),
        .load      (rx_load),
        .load_data ('0),
        .shift     (rx_shift),
        .serial_in (r_data),
        .data      (rx_data),
        .count     (rx_count)
    );

    // Only the TX MSB and the low RX byte are ever observed.
    assign unused_bits = ^{tx_data[FRAME_W-2:0], rx_data[FRAME_W-1:DATA_W]};

    assign req_ready = (state == ST_IDLE);
    assign accept    = req_valid && (state == ST_IDLE);
    assign tmr_tc    = (tmr <= TMR_W'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            tmr         <= '0;
            write_q     <= 1'b0;
            wdata_q     <= '0;
            addr        <= 1'b0;
            w_data      <= 1'b0;
            master_en   <= 1'b0;
            bus_request <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_status  <= '0;
            rsp_rdata   <= '0;
        end else begin
            state       <= state_d;
            tmr         <= tmr_d;
            addr        <= addr_d;
            w_data      <= w_data_d;
            master_en   <= master_en_d;
            bus_request <= bus_request_d;
            rsp_valid   <= rsp_valid_d;
            rsp_status  <= rsp_status_d;
            rsp_rdata   <= rsp_rdata_d;
            if (accept) begin
                write_q <= req_write;
                wdata_q <= req_wdata;
            end
        end
    end

    always_comb begin
        state_d       = state;
        tmr_d         = tmr;
        addr_d        = 1'b0;
        w_data_d      = 1'b0;
        master_en_d   = master_en;
        bus_request_d = bus_request;
        rsp_valid_d   = 1'b0;
        rsp_status_d  = rsp_status;
        rsp_rdata_d   = rsp_rdata;
        tx_load       = 1'b0;
        tx_load_data  = '0;
        tx_shift      = 1'b0;
        rx_load       = 1'b0;
        rx_shift      = 1'b0;

        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    state_d       = ST_REQ;
                    bus_request_d = 1'b1;
                    tx_load       = 1'b1;
                    tx_load_data  = {req_slave, req_write, req_addr};
                end
            end
            ST_REQ: begin
                if (bus_grant) begin
                    state_d     = ST_START;
                    master_en_d = 1'b1;
                    addr_d      = 1'b1;
                end
            end
            ST_START: begin
                state_d  = ST_ADDR;
                tx_shift = 1'b1;
                addr_d   = tx_data[FRAME_W-1];
            end
            ST_ADDR: begin
                if (tx_count == BITCNT_W'(FRAME_W)) begin
                    state_d = ST_WAIT_RESP;
                    tmr_d   = TMR_W'(RESP_TIMEOUT);
                end else begin
                    tx_shift = 1'b1;
                    addr_d   = tx_data[FRAME_W-1];
                end
            end
            ST_WAIT_RESP: begin
                if (response == RESP_OK) begin
                    if (write_q) begin
                        // First write bit goes straight out; the rest are queued in TX.
                        state_d      = ST_WDATA;
                        w_data_d     = wdata_q[DATA_W-1];
                        tx_load      = 1'b1;
                        tx_load_data = {wdata_q[DATA_W-2:0], {(FRAME_W-DATA_W+1){1'b0}}};
                    end else begin
                        state_d = ST_RDATA;
                        rx_load = 1'b1;
                    end
                end else if (response == RESP_BUSY) begin
                    state_d       = ST_SPLIT_WAIT;
                    master_en_d   = 1'b0;
                    bus_request_d = 1'b0;
                    tmr_d         = TMR_W'(SPLIT_TIMEOUT);
                end else if (tmr_tc) begin
                    state_d       = ST_FINISH;
                    master_en_d   = 1'b0;
                    bus_request_d = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_status_d  = STAT_NAK;
                end else begin
                    tmr_d = tmr - TMR_W'(1);
                end
            end
            ST_SPLIT_WAIT: begin
                if (bus_grant) begin
                    state_d       = ST_WAIT_RESP;
                    master_en_d   = 1'b1;
                    bus_request_d = 1'b1;
                    tmr_d         = TMR_W'(RESP_TIMEOUT);
                end else if (tmr_tc) begin
                    state_d      = ST_FINISH;
                    rsp_valid_d  = 1'b1;
                    rsp_status_d = STAT_SPLIT_TO;
                end else begin
                    tmr_d = tmr - TMR_W'(1);
                end
            end
            ST_WDATA: begin
                if (tx_count == BITCNT_W'(DATA_W-1)) begin
                    state_d = ST_WAIT_DONE;
                    tmr_d   = TMR_W'(DONE_TIMEOUT);
                end else begin
                    tx_shift = 1'b1;
                    w_data_d = tx_data[FRAME_W-1];
                end
            end
            ST_RDATA: begin
                rx_shift = 1'b1;
                if (rx_count == BITCNT_W'(DATA_W-1)) begin
                    state_d = ST_WAIT_DONE;
                    tmr_d   = TMR_W'(DONE_TIMEOUT);
                end
            end
            ST_WAIT_DONE: begin
                if (response == RESP_DONE) begin
                    state_d       = ST_FINISH;
                    master_en_d   = 1'b0;
                    bus_request_d = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_status_d  = STAT_OK;
                    if (!write_q) begin
                        rsp_rdata_d = rx_data[DATA_W-1:0];
                    end
                end else if (tmr_tc) begin
                    state_d       = ST_FINISH;
                    master_en_d   = 1'b0;
                    bus_request_d = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_status_d  = STAT_DONE_TO;
                end else begin
                    tmr_d = tmr - TMR_W'(1);
                end
            end
            ST_FINISH: begin
                state_d       = ST_IDLE;
                master_en_d   = 1'b0;
                bus_request_d = 1'b0;
            end
            default: begin
                state_d       = ST_IDLE;
                master_en_d   = 1'b0;
                bus_request_d = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_master_interface.sv
// Directed bench for master_interface: bench-side slave/arbiter, scoreboard of expected completions.
module tb_master_interface;

    localparam logic [1:0] R_NAK  = 2'b00;
    localparam logic [1:0] R_BUSY = 2'b01;
    localparam logic [1:0] R_OK   = 2'b10;
    localparam logic [1:0] R_DONE = 2'b11;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_write;
    logic [1:0]  req_slave;
    logic [11:0] req_addr;
    logic [7:0]  req_wdata;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic [1:0]  rsp_status;
    logic        bus_request, bus_grant, master_en;
    logic        addr, w_data, r_data;
    logic [1:0]  response;

    int checks = 0;
    int errors = 0;
    int pcyc   = 0;

    typedef struct {
        logic [1:0] st;
        logic [7:0] rd;
        int         lat;
        int         t;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    master_interface dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_slave   (req_slave),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_status  (rsp_status),
        .bus_request (bus_request),
        .bus_grant   (bus_grant),
        .master_en   (master_en),
        .addr        (addr),
        .w_data      (w_data),
        .r_data      (r_data),
        .response    (response)
    );

    always #5 clk = ~clk;

    always @(posedge clk) pcyc <= pcyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Completion monitor: every rsp_valid pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rsp_valid === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: rsp_valid=1 with no outstanding request (t=%0t)", $time);
            end else begin
                mon_e = sb.pop_front();
                chk("rsp_status", 32'(rsp_status), 32'(mon_e.st));
                chk("rsp_rdata", 32'(rsp_rdata), 32'(mon_e.rd));
                if (mon_e.lat >= 0) chk("latency", pcyc - mon_e.t - 1, mon_e.lat);
            end
        end
    end

    function automatic logic [14:0] fr(input logic [1:0] sl, input logic wr, input logic [11:0] a);
        return {sl, wr, a};
    endfunction

    task automatic issue(input logic wr, input logic [1:0] sl, input logic [11:0] a, input logic [7:0] wd,
                         input bit track, input logic [1:0] st, input logic [7:0] rd, input int lat);
        @(negedge clk);
        req_valid = 1'b1;
        req_write = wr;
        req_slave = sl;
        req_addr  = a;
        req_wdata = wd;
        chk("req_ready_idle", 32'(req_ready), 32'd1);
        if (track) sb.push_back('{st, rd, lat, pcyc});
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_start(output int waited);
        waited = 0;
        while (!(addr === 1'b1 && master_en === 1'b1) && waited < 64) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 64) begin
            checks++;
            errors++;
            $display("FAIL start_timeout: no start bit within 64 cycles (t=%0t)", $time);
        end
    endtask

    // Called at T0; returns at T16.
    task automatic get_frame(input logic [14:0] exp_frame);
        logic [14:0] f = '0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            f = {f[13:0], addr};
        end
        chk("addr_frame", 32'(f), 32'(exp_frame));
        @(negedge clk);
        chk("addr_idle_after_frame", 32'(addr), 32'd0);
    endtask

    // Called in the cycle OK is to be driven; returns in the first WAIT_DONE cycle.
    task automatic send_ok_collect_w(input logic [7:0] exp_wd, input logic [1:0] resp_during);
        logic [7:0] wd = '0;
        response = R_OK;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            response = resp_during;
            wd = {wd[6:0], w_data};
        end
        chk("w_data_bits", 32'(wd), 32'(exp_wd));
        @(negedge clk);
        response = R_NAK;
        chk("w_data_idle", 32'(w_data), 32'd0);
    endtask

    // Called at T17; returns at T27 (completion cycle of a nominal read).
    task automatic send_ok_drive_r(input logic [7:0] d);
        response = R_OK;
        for (int i = 7; i >= 0; i--) begin
            @(negedge clk);
            response = R_NAK;
            r_data   = d[i];
        end
        @(negedge clk);
        r_data   = 1'b0;
        response = R_DONE;
        @(negedge clk);
        response = R_NAK;
        chk("rsp_valid_read", 32'(rsp_valid), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        logic seen;

        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_slave = '0; req_addr = '0;
        req_wdata = '0; bus_grant = 1'b1; r_data = 1'b0; response = R_NAK;
        repeat (3) @(negedge clk);
        chk("rst_addr", 32'(addr), 32'd0);
        chk("rst_w_data", 32'(w_data), 32'd0);
        chk("rst_master_en", 32'(master_en), 32'd0);
        chk("rst_bus_request", 32'(bus_request), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_status", 32'(rsp_status), 32'd0);
        chk("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        reset = 1'b0;

        // Nominal write; OK held during the data phase must be ignored.
        issue(1'b1, 2'b01, 12'hA5C, 8'h3C, 1'b1, 2'b00, 8'h00, 29);
        wait_start(w);
        get_frame(15'b01_1_1010_0101_1100);
        @(negedge clk);
        send_ok_collect_w(8'h3C, R_OK);
        @(negedge clk); response = R_DONE;
        @(negedge clk); response = R_NAK;
        chk("rsp_valid_write", 32'(rsp_valid), 32'd1);
        @(negedge clk);
        chk("bus_request_after_write", 32'(bus_request), 32'd0);

        // Nominal read.
        issue(1'b0, 2'b10, 12'h00F, 8'h00, 1'b1, 2'b00, 8'hA7, 28);
        wait_start(w);
        get_frame(fr(2'b10, 1'b0, 12'h00F));
        @(negedge clk);
        send_ok_drive_r(8'hA7);

        // No slave answers, grant arrives 3 cycles late: NAK timeout, rdata held.
        bus_grant = 1'b0;
        issue(1'b0, 2'b00, 12'h123, 8'h00, 1'b1, 2'b01, 8'hA7, 28);
        chk("req_bus_request", 32'(bus_request), 32'd1);
        chk("req_master_en", 32'(master_en), 32'd0);
        repeat (3) @(negedge clk);
        bus_grant = 1'b1;
        wait_start(w);
        repeat (15) @(negedge clk);
        repeat (8) @(negedge clk);
        chk("nak_not_early", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        chk("nak_rsp_valid", 32'(rsp_valid), 32'd1);
        @(negedge clk);
        chk("nak_bus_request_low", 32'(bus_request), 32'd0);
        chk("nak_master_en_low", 32'(master_en), 32'd0);

        // Split: BUSY, grant low 5 cycles, re-grant, OK without a new address frame.
        issue(1'b1, 2'b11, 12'h7E1, 8'hC5, 1'b1, 2'b00, 8'hA7, -1);
        wait_start(w);
        get_frame(fr(2'b11, 1'b1, 12'h7E1));
        @(negedge clk); response = R_BUSY;
        @(negedge clk); response = R_NAK; bus_grant = 1'b0;
        chk("split_master_en", 32'(master_en), 32'd0);
        chk("split_bus_request", 32'(bus_request), 32'd0);
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            seen = seen | master_en | bus_request | addr;
        end
        @(negedge clk); bus_grant = 1'b1;
        seen = seen | master_en | bus_request | addr;
        chk("split_quiet", 32'(seen), 32'd0);
        @(negedge clk);
        chk("regrant_master_en", 32'(master_en), 32'd1);
        send_ok_collect_w(8'hC5, R_NAK);
        @(negedge clk); response = R_DONE;
        @(negedge clk); response = R_NAK;
        chk("rsp_valid_split", 32'(rsp_valid), 32'd1);

        // Reset at T10 of a write; no completion for it, then a normal read.
        issue(1'b1, 2'b01, 12'h0AA, 8'h55, 1'b0, 2'b00, 8'h00, -1);
        wait_start(w);
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_addr", 32'(addr), 32'd0);
        chk("midrst_master_en", 32'(master_en), 32'd0);
        chk("midrst_bus_request", 32'(bus_request), 32'd0);
        chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("midrst_req_ready", 32'(req_ready), 32'd1);
        issue(1'b0, 2'b01, 12'h0AA, 8'h00, 1'b1, 2'b00, 8'h5A, 28);
        wait_start(w);
        get_frame(fr(2'b01, 1'b0, 12'h0AA));
        @(negedge clk);
        send_ok_drive_r(8'h5A);

        // Back-to-back reads with req_valid held high.
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_slave = 2'b10; req_addr = 12'h111;
        sb.push_back('{2'b00, 8'h3E, 28, pcyc});
        @(negedge clk);
        chk("req_ready_busy", 32'(req_ready), 32'd0);
        req_slave = 2'b00; req_addr = 12'hFFF;
        sb.push_back('{2'b00, 8'hC1, -1, 0});
        wait_start(w);
        get_frame(fr(2'b10, 1'b0, 12'h111));
        @(negedge clk);
        send_ok_drive_r(8'h3E);
        wait_start(w);
        chk("b2b_start_gap", 32'(w), 32'd3);
        req_valid = 1'b0;
        get_frame(fr(2'b00, 1'b0, 12'hFFF));
        @(negedge clk);
        send_ok_drive_r(8'hC1);

        // Write that never sees DONE: done timeout.
        issue(1'b1, 2'b00, 12'h001, 8'h81, 1'b1, 2'b10, 8'hC1, 31);
        wait_start(w);
        get_frame(fr(2'b00, 1'b1, 12'h001));
        @(negedge clk);
        send_ok_collect_w(8'h81, R_NAK);
        repeat (3) @(negedge clk);
        chk("done_to_not_early", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        chk("done_to_rsp_valid", 32'(rsp_valid), 32'd1);

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
